// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the 16-bit CPU main control and ALUControl.
package cpu_ctrl_pkg;

  localparam int unsigned OPC_W   = 4;
  localparam int unsigned ALUOP_W = 2;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned ST_W    = 4;

  // Instruction opcodes (IR[15:12])
  localparam logic [OPC_W-1:0] OP_R_LOGIC = 4'b0000;
  localparam logic [OPC_W-1:0] OP_R_ARITH = 4'b0001;
  localparam logic [OPC_W-1:0] OP_R_SHIFT = 4'b0010;
  localparam logic [OPC_W-1:0] OP_ADDI    = 4'b0100;
  localparam logic [OPC_W-1:0] OP_SUBI    = 4'b0101;
  localparam logic [OPC_W-1:0] OP_LW      = 4'b0110;
  localparam logic [OPC_W-1:0] OP_SW      = 4'b0111;
  localparam logic [OPC_W-1:0] OP_BEQ     = 4'b1000;
  localparam logic [OPC_W-1:0] OP_BNE     = 4'b1001;
  localparam logic [OPC_W-1:0] OP_J       = 4'b1010;
  localparam logic [OPC_W-1:0] OP_SLTI    = 4'b1011;
  localparam logic [OPC_W-1:0] OP_HALT    = 4'b1111;

  typedef enum logic [ALUOP_W-1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_SLTI  = 2'b11
  } aluop_e;

  typedef enum logic [SEL_W-1:0] {
    SRCB_REGB = 2'b00,
    SRCB_ONE  = 2'b01,
    SRCB_IMM  = 2'b10,
    SRCB_BOFF = 2'b11
  } alusrcb_e;

  typedef enum logic [SEL_W-1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10,
    PCSRC_RSVD   = 2'b11
  } pcsrc_e;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_EXEC_R   = 4'd3,
    ST_EXEC_I   = 4'd4,
    ST_MEM_ADDR = 4'd5,
    ST_MEM_RD   = 4'd6,
    ST_MEM_WR   = 4'd7,
    ST_WB_ALU   = 4'd8,
    ST_WB_MEM   = 4'd9,
    ST_BRANCH   = 4'd10,
    ST_JUMP     = 4'd11,
    ST_HALT     = 4'd12
  } state_e;

  // Datapath control bundle decoded from the current state
  typedef struct packed {
    logic [ALUOP_W-1:0] alu_op;
    logic               alu_src_a;
    logic [SEL_W-1:0]   alu_src_b;
    logic               pc_write;
    logic [SEL_W-1:0]   pc_source;
    logic               i_or_d;
    logic               mem_read;
    logic               mem_write;
    logic               ir_write;
    logic               reg_dst;
    logic               mem_to_reg;
    logic               reg_write;
    logic               halted;
    logic               illegal_op;
  } ctrl_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts MemReady wait cycles in a memory state; flags when the limit is reached.
module mem_wait_timer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic Clock,
  input  logic Reset,
  input  logic clear,
  input  logic MemReady,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

  logic [CNT_W-1:0] r_count;

  // Wait counter: cleared between memory accesses, saturates at the limit
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (!MemReady && (r_count != CNT_W'(MEM_TIMEOUT))) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign expired = (r_count == CNT_W'(MEM_TIMEOUT));

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM: sequences fetch/decode/execute/memory/writeback.
module multicycle_control
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned STATE_W     = 4
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [OPC_W-1:0]   OPCode,
  input  logic               Zero,
  input  logic               MemReady,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               ALUSrcA,
  output logic [SEL_W-1:0]   ALUSrcB,
  output logic               PCWrite,
  output logic [SEL_W-1:0]   PCSource,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               MemToReg,
  output logic               RegWrite,
  output logic               Halted,
  output logic               IllegalOp,
  output logic               BusError,
  output logic [STATE_W-1:0] State
);

  state_e r_state;
  state_e w_next_state;
  ctrl_t  w_ctrl;
  logic   r_reg_dst;
  logic   r_bus_error;
  logic   w_set_bus_error;
  logic   w_timer_clear;
  logic   w_expired;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .Clock   (Clock),
    .Reset   (Reset),
    .clear   (w_timer_clear),
    .MemReady(MemReady),
    .expired (w_expired)
  );

  // Counter only runs while lingering in a memory state; any transition restarts it
  assign w_timer_clear = !((r_state inside {ST_FETCH, ST_MEM_RD, ST_MEM_WR}) &&
                           (w_next_state == r_state));

  // State register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Sticky bus error and the writeback destination chosen during execute
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_bus_error <= 1'b0;
      r_reg_dst   <= 1'b0;
    end else begin
      r_bus_error <= r_bus_error | w_set_bus_error;
      if (r_state == ST_EXEC_R)      r_reg_dst <= 1'b1;
      else if (r_state == ST_EXEC_I) r_reg_dst <= 1'b0;
    end
  end

  // Next-state and Moore output decode; memory states qualified by MemReady
  always_comb begin
    w_next_state    = r_state;
    w_ctrl          = '0;
    w_set_bus_error = 1'b0;
    case (r_state)
      ST_IDLE: w_next_state = ST_FETCH;
      ST_FETCH: begin
        w_ctrl.mem_read  = 1'b1;
        w_ctrl.alu_src_b = SRCB_ONE;
        if (MemReady) begin
          w_ctrl.ir_write = 1'b1;
          w_ctrl.pc_write = 1'b1;
          w_next_state    = ST_DECODE;
        end else if (w_expired) begin
          w_set_bus_error = 1'b1;
          w_next_state    = ST_HALT;
        end
      end
      ST_DECODE: begin
        w_ctrl.alu_src_b = SRCB_BOFF;
        case (OPCode)
          OP_R_LOGIC, OP_R_ARITH, OP_R_SHIFT: w_next_state = ST_EXEC_R;
          OP_ADDI, OP_SUBI, OP_SLTI:          w_next_state = ST_EXEC_I;
          OP_LW, OP_SW:                       w_next_state = ST_MEM_ADDR;
          OP_BEQ, OP_BNE:                     w_next_state = ST_BRANCH;
          OP_J:                               w_next_state = ST_JUMP;
          OP_HALT:                            w_next_state = ST_HALT;
          default: begin
            w_ctrl.illegal_op = 1'b1;
            w_next_state      = ST_FETCH;
          end
        endcase
      end
      ST_EXEC_R: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_REGB;
        w_ctrl.alu_op    = ALUOP_RTYPE;
        w_next_state     = ST_WB_ALU;
      end
      ST_EXEC_I: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_IMM;
        case (OPCode)
          OP_SUBI: w_ctrl.alu_op = ALUOP_SUB;
          OP_SLTI: w_ctrl.alu_op = ALUOP_SLTI;
          default: w_ctrl.alu_op = ALUOP_ADD;
        endcase
        w_next_state = ST_WB_ALU;
      end
      ST_WB_ALU: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.reg_dst   = r_reg_dst;
        w_next_state     = ST_FETCH;
      end
      ST_MEM_ADDR: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_next_state     = (OPCode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
      end
      ST_MEM_RD: begin
        w_ctrl.i_or_d   = 1'b1;
        w_ctrl.mem_read = 1'b1;
        if (MemReady) begin
          w_next_state = ST_WB_MEM;
        end else if (w_expired) begin
          w_set_bus_error = 1'b1;
          w_next_state    = ST_HALT;
        end
      end
      ST_WB_MEM: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
        w_next_state      = ST_FETCH;
      end
      ST_MEM_WR: begin
        w_ctrl.i_or_d    = 1'b1;
        w_ctrl.mem_write = 1'b1;
        if (MemReady) begin
          w_next_state = ST_FETCH;
        end else if (w_expired) begin
          w_set_bus_error = 1'b1;
          w_next_state    = ST_HALT;
        end
      end
      ST_BRANCH: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_REGB;
        w_ctrl.alu_op    = ALUOP_SUB;
        w_ctrl.pc_source = PCSRC_ALUOUT;
        w_ctrl.pc_write  = (OPCode == OP_BNE) ? ~Zero : Zero;
        w_next_state     = ST_FETCH;
      end
      ST_JUMP: begin
        w_ctrl.pc_source = PCSRC_JUMP;
        w_ctrl.pc_write  = 1'b1;
        w_next_state     = ST_FETCH;
      end
      ST_HALT: w_ctrl.halted = 1'b1;
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign ALUOp     = w_ctrl.alu_op;
  assign ALUSrcA   = w_ctrl.alu_src_a;
  assign ALUSrcB   = w_ctrl.alu_src_b;
  assign PCWrite   = w_ctrl.pc_write;
  assign PCSource  = w_ctrl.pc_source;
  assign IorD      = w_ctrl.i_or_d;
  assign MemRead   = w_ctrl.mem_read;
  assign MemWrite  = w_ctrl.mem_write;
  assign IRWrite   = w_ctrl.ir_write;
  assign RegDst    = w_ctrl.reg_dst;
  assign MemToReg  = w_ctrl.mem_to_reg;
  assign RegWrite  = w_ctrl.reg_write;
  assign Halted    = w_ctrl.halted;
  assign IllegalOp = w_ctrl.illegal_op;
  assign BusError  = r_bus_error;
  assign State     = STATE_W'(r_state);

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: driver queues per-cycle expectations, monitor checks.
module tb_multicycle_control;
  import cpu_ctrl_pkg::*;

  localparam int MEM_TO = 15;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [3:0] OPCode;
  logic       Zero;
  logic       MemReady;
  logic [1:0] ALUOp;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       PCWrite;
  logic [1:0] PCSource;
  logic       IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg, RegWrite;
  logic       Halted, IllegalOp, BusError;
  logic [3:0] State;

  multicycle_control #(.MEM_TIMEOUT(MEM_TO), .STATE_W(4)) dut (
    .Clock(Clock), .Reset(Reset), .OPCode(OPCode), .Zero(Zero), .MemReady(MemReady),
    .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCWrite(PCWrite),
    .PCSource(PCSource), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegDst(RegDst), .MemToReg(MemToReg), .RegWrite(RegWrite),
    .Halted(Halted), .IllegalOp(IllegalOp), .BusError(BusError), .State(State)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [3:0] st;
    logic [1:0] aluop;
    logic       srca;
    logic [1:0] srcb;
    logic       pcwrite;
    logic [1:0] pcsrc;
    logic       iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite;
    logic       halted, illegal, buserr;
  } obs_t;

  typedef enum int {K_R, K_I, K_LW, K_SW, K_BR, K_J, K_HALT, K_ILL} kind_e;

  obs_t  exp_q[$];
  string name_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  logic  m_berr  = 1'b0;

  // Instruction class straight from the opcode table
  function automatic kind_e op_kind(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010: return K_R;
      4'b0100, 4'b0101, 4'b1011: return K_I;
      4'b0110:                   return K_LW;
      4'b0111:                   return K_SW;
      4'b1000, 4'b1001:          return K_BR;
      4'b1010:                   return K_J;
      4'b1111:                   return K_HALT;
      default:                   return K_ILL;
    endcase
  endfunction

  // Expected control word for one cycle spent in phase ph
  function automatic obs_t model(input state_e ph, input logic [3:0] op,
                                 input logic zero, input logic ready);
    obs_t o = '0;
    o.st     = ph;
    o.buserr = m_berr;
    case (ph)
      ST_FETCH:    begin o.memread = 1; o.srcb = 2'b01; o.irwrite = ready; o.pcwrite = ready; end
      ST_DECODE:   begin o.srcb = 2'b11; o.illegal = (op_kind(op) == K_ILL); end
      ST_EXEC_R:   begin o.srca = 1; o.srcb = 2'b00; o.aluop = 2'b10; end
      ST_EXEC_I:   begin
        o.srca = 1; o.srcb = 2'b10;
        o.aluop = (op == 4'b0101) ? 2'b01 : (op == 4'b1011) ? 2'b11 : 2'b00;
      end
      ST_WB_ALU:   begin o.regwrite = 1; o.regdst = (op_kind(op) == K_R); end
      ST_MEM_ADDR: begin o.srca = 1; o.srcb = 2'b10; end
      ST_MEM_RD:   begin o.iord = 1; o.memread = 1; end
      ST_WB_MEM:   begin o.regwrite = 1; o.memtoreg = 1; end
      ST_MEM_WR:   begin o.iord = 1; o.memwrite = 1; end
      ST_BRANCH:   begin
        o.srca = 1; o.aluop = 2'b01; o.pcsrc = 2'b01;
        o.pcwrite = (op == 4'b1001) ? ~zero : zero;
      end
      ST_JUMP:     begin o.pcsrc = 2'b10; o.pcwrite = 1; end
      ST_HALT:     o.halted = 1;
      default:     o = '0;
    endcase
    return o;
  endfunction

  function automatic obs_t actual();
    obs_t a;
    a.st = State; a.aluop = ALUOp; a.srca = ALUSrcA; a.srcb = ALUSrcB;
    a.pcwrite = PCWrite; a.pcsrc = PCSource; a.iord = IorD; a.memread = MemRead;
    a.memwrite = MemWrite; a.irwrite = IRWrite; a.regdst = RegDst; a.memtoreg = MemToReg;
    a.regwrite = RegWrite; a.halted = Halted; a.illegal = IllegalOp; a.buserr = BusError;
    return a;
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask

  // Drive one cycle of inputs and queue the expected outputs for that cycle
  task automatic cyc(input state_e ph, input logic [3:0] op, input logic [3:0] drv_op,
                     input logic zero, input logic ready, input string tag);
    OPCode   = drv_op;
    Zero     = zero;
    MemReady = ready;
    exp_q.push_back(model(ph, op, zero, ready));
    name_q.push_back($sformatf("%s/%s/op=%b", tag, ph.name(), op));
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset  = 1'b0;
    m_berr = 1'b0;
    cyc(ST_IDLE, 4'd0, 4'($urandom), 1'($urandom), 1'($urandom), "reset");
    cyc(ST_IDLE, 4'd0, 4'($urandom), 1'($urandom), 1'($urandom), "reset");
    Reset = 1'b1;
    cyc(ST_IDLE, 4'd0, 4'($urandom), 1'($urandom), 1'($urandom), "release");
  endtask

  // One whole instruction from FETCH; fw/mw are MemReady-low cycles before ready
  task automatic run_instr(input logic [3:0] op, input int fw, input int mw,
                           input logic zero, input string tag);
    state_e ph[$];
    int     w;
    ph = '{ST_FETCH, ST_DECODE};
    case (op_kind(op))
      K_R:    ph.push_back(ST_EXEC_R);
      K_I:    ph.push_back(ST_EXEC_I);
      K_LW:   begin ph.push_back(ST_MEM_ADDR); ph.push_back(ST_MEM_RD); end
      K_SW:   begin ph.push_back(ST_MEM_ADDR); ph.push_back(ST_MEM_WR); end
      K_BR:   ph.push_back(ST_BRANCH);
      K_J:    ph.push_back(ST_JUMP);
      K_HALT: ph.push_back(ST_HALT);
      default: ;
    endcase
    if (op_kind(op) inside {K_R, K_I}) ph.push_back(ST_WB_ALU);
    if (op_kind(op) == K_LW)           ph.push_back(ST_WB_MEM);
    foreach (ph[i]) begin
      if (ph[i] inside {ST_FETCH, ST_MEM_RD, ST_MEM_WR}) begin
        w = (ph[i] == ST_FETCH) ? fw : mw;
        for (int k = 0; k < w && k <= MEM_TO; k++)
          cyc(ph[i], op, (ph[i] == ST_FETCH) ? 4'($urandom) : op, 1'($urandom), 1'b0, tag);
        if (w > MEM_TO) begin
          m_berr = 1'b1;
          repeat (3) cyc(ST_HALT, op, op, 1'($urandom), 1'($urandom), tag);
          do_reset();
          return;
        end
        cyc(ph[i], op, (ph[i] == ST_FETCH) ? 4'($urandom) : op, 1'($urandom), 1'b1, tag);
      end else if (ph[i] == ST_HALT) begin
        repeat (3) cyc(ST_HALT, op, op, 1'($urandom), 1'($urandom), tag);
        do_reset();
        return;
      end else if (ph[i] == ST_BRANCH) begin
        cyc(ph[i], op, op, zero, 1'($urandom), tag);
      end else begin
        cyc(ph[i], op, op, 1'($urandom), 1'($urandom), tag);
      end
    end
  endtask

  function automatic int rand_wait();
    int r = int'($urandom_range(0, 99));
    if (r < 70) return 0;
    if (r < 94) return int'($urandom_range(1, 3));
    if (r < 98) return MEM_TO;
    return MEM_TO + 1;
  endfunction

  // Monitor: compare every cycle that has a queued expectation
  initial begin
    obs_t  e, a;
    string nm;
    forever begin
      @(negedge Clock);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = actual();
        n_tests++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL %s: got %h (state %0d) expected %h (state %0d)", nm, a, a.st, e, e.st);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b0; OPCode = '0; Zero = 1'b0; MemReady = 1'b0;
    @(posedge Clock); #1;
    do_reset();

    // Directed cases
    run_instr(4'b0000, 0, 0, 1'b0, "r_logic");
    run_instr(4'b1011, 0, 0, 1'b0, "slti");
    run_instr(4'b0110, 0, 2, 1'b0, "lw_wait2");
    run_instr(4'b1000, 0, 0, 1'b1, "beq_taken");
    run_instr(4'b1001, 0, 0, 1'b1, "bne_not_taken");
    run_instr(4'b1001, 1, 0, 1'b0, "bne_taken");
    run_instr(4'b1010, 0, 0, 1'b0, "jump");
    run_instr(4'b1100, 0, 0, 1'b0, "illegal");
    run_instr(4'b0101, 0, 0, 1'b0, "subi");
    run_instr(4'b0111, MEM_TO, MEM_TO, 1'b0, "sw_limit_ok");
    run_instr(4'b0110, 2, MEM_TO, 1'b0, "lw_limit_ok");
    run_instr(4'b0000, MEM_TO + 1, 0, 1'b0, "fetch_timeout");
    run_instr(4'b0110, 0, MEM_TO + 1, 1'b0, "mem_rd_timeout");
    run_instr(4'b1111, 0, 0, 1'b0, "halt");

    // Reset asserted while a store is in flight
    cyc(ST_FETCH,    4'b0111, 4'b0111, 1'b0, 1'b1, "sw_abort");
    cyc(ST_DECODE,   4'b0111, 4'b0111, 1'b0, 1'b0, "sw_abort");
    cyc(ST_MEM_ADDR, 4'b0111, 4'b0111, 1'b0, 1'b0, "sw_abort");
    MemReady = 1'b0;
    #1;
    check("memwrite_before_reset", 32'(MemWrite), 32'd1);
    Reset = 1'b0;
    #1;
    check("memwrite_async_drop", 32'(MemWrite), 32'd0);
    check("state_async_idle", 32'(State), 32'(ST_IDLE));
    check("regwrite_after_reset", 32'(RegWrite), 32'd0);
    @(posedge Clock); #1;
    do_reset();
    run_instr(4'b0001, 0, 0, 1'b0, "after_abort");

    // Randomized instruction stream
    for (int n = 0; n < 300; n++)
      run_instr(4'($urandom), rand_wait(), rand_wait(), 1'($urandom), $sformatf("rand%0d", n));

    @(negedge Clock);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
